// File: rtl/velocity_cell_reader_pkg.sv
// Shared definitions for the velocity cell reader: FSM encoding, default RAM
// latency, count-field position and a small pointer-width helper.
package velocity_cell_reader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNT_REQ  = 3'd1,
        CNT_WAIT = 3'd2,
        STREAM   = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Cycles from mem_rden/mem_address to valid mem_q on the velocity RAM.
    localparam int DEFAULT_READ_LATENCY = 2;

    // LSB of the particle-count field inside the address-0 word.
    localparam int COUNT_LSB = 0;

    // Bits needed to index 'depth' entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/velocity_read_fifo.sv
// Small synchronous FIFO that absorbs records returning from the RAM pipeline.
// Pushes into a full FIFO and pops from an empty one are ignored.
module velocity_read_fifo
    import velocity_cell_reader_pkg::*;
#(
    parameter int WIDTH = 104,
    parameter int DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [WIDTH-1:0]                   push_data,
    input  logic                               pop,
    output logic [WIDTH-1:0]                   head_data,
    output logic [ptr_width(DEPTH+1)-1:0]      occupancy,
    output logic                               empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = ptr_width(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Advance a pointer, wrapping at DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push   = push && (occupancy != OCC_W'(DEPTH));
    assign do_pop    = pop && (occupancy != '0);
    assign empty     = (occupancy == '0);
    assign head_data = store[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/velocity_cell_reader.sv
// Streams one cell's velocity records out of the single-port velocity RAM:
// reads the count word at address 0, then addresses 1..count, and presents
// each {vz, vy, vx} record on a valid/ready stream through a credit-limited FIFO.
module velocity_cell_reader
    import velocity_cell_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  count_clamped,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int FIFO_DEPTH = READ_LATENCY + 1;
    localparam int ENTRY_W    = DATA_WIDTH + ADDR_WIDTH;
    localparam int OCC_W      = ptr_width(FIFO_DEPTH + 1);
    localparam int WAIT_W     = ptr_width(READ_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_ONE  = 1;

    state_t                 state;
    state_t                 state_next;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH:0]    next_addr;
    logic [ADDR_WIDTH-1:0]  raw_count;
    logic                   capture;
    logic                   issue;
    logic                   last_hs;
    int                     in_flight;
    int                     fill;

    logic [READ_LATENCY-1:0] tag_vld_p;
    logic [ADDR_WIDTH-1:0]   tag_idx_p [READ_LATENCY];

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     fifo_head;
    logic [OCC_W-1:0]       fifo_occ;
    logic                   fifo_empty;

    // Saturate the raw count to the last valid RAM address.
    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_COUNT) ? MAX_COUNT : raw;
    endfunction

    assign raw_count = mem_q[COUNT_LSB +: ADDR_WIDTH];
    assign mem_wren  = 1'b0;
    assign mem_data  = '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Reads still travelling through the RAM pipeline.
    always_comb begin
        in_flight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (tag_vld_p[i]) in_flight = in_flight + 1;
        end
    end

    // Next state, RAM port and credit-based issue decision.
    always_comb begin
        state_next  = state;
        mem_rden    = 1'b0;
        mem_address = '0;
        issue       = 1'b0;
        capture     = 1'b0;
        // A pop this cycle frees a slot, so it counts as a credit right away.
        fill        = int'(fifo_occ) + in_flight - (fifo_pop ? 1 : 0);
        case (state)
            IDLE: begin
                if (start) state_next = CNT_REQ;
            end
            CNT_REQ: begin
                mem_rden   = 1'b1;
                state_next = CNT_WAIT;
            end
            CNT_WAIT: begin
                if (wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
                    capture    = 1'b1;
                    state_next = (raw_count == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                issue       = (next_addr <= {1'b0, count}) && (fill < FIFO_DEPTH);
                mem_rden    = issue;
                mem_address = next_addr[ADDR_WIDTH-1:0];
                if (last_hs) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Count capture, clamp flag, latency wait counter and read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            count_clamped <= 1'b0;
            wait_cnt      <= '0;
            next_addr     <= '0;
        end else begin
            if (state == IDLE && start) count_clamped <= 1'b0;
            if (state == CNT_REQ)       wait_cnt <= '0;
            else if (state == CNT_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (capture) begin
                count         <= clamp_count(raw_count);
                count_clamped <= (raw_count > MAX_COUNT);
                next_addr     <= ADDR_ONE;
            end else if (issue) begin
                next_addr <= next_addr + ADDR_ONE;
            end
        end
    end

    // ---- p0..pN: read-tag valid pipeline, cleared on reset so stale RAM data is dropped ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    // Index tags ride alongside the valid pipeline.
    always_ff @(posedge clk) begin
        tag_idx_p[0] <= next_addr[ADDR_WIDTH-1:0];
        for (int i = 1; i < READ_LATENCY; i++) tag_idx_p[i] <= tag_idx_p[i-1];
    end

    // ---- RAM return: tagged data enters the FIFO ----
    assign fifo_push = tag_vld_p[READ_LATENCY-1];
    assign fifo_pop  = out_valid && out_ready;

    velocity_read_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({mem_q, tag_idx_p[READ_LATENCY-1]}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .occupancy (fifo_occ),
        .empty     (fifo_empty)
    );

    // ---- Output stream: FIFO head, forced to zero while empty ----
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head[ENTRY_W-1:ADDR_WIDTH] : '0;
    assign out_index = out_valid ? fifo_head[ADDR_WIDTH-1:0] : '0;
    assign out_last  = out_valid && (fifo_head[ADDR_WIDTH-1:0] == count);
    assign last_hs   = fifo_pop && out_last;

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Directed self-checking bench for velocity_cell_reader with a 2-cycle RAM model.
module tb_velocity_cell_reader;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, count_clamped, mem_rden, mem_wren, out_valid, out_last;
    logic [AW-1:0] count, mem_address, out_index;
    logic [DW-1:0] mem_data, mem_q, out_data;
    logic [DW-1:0] ram [PN];
    logic [DW-1:0] q_s1, q_s2;
    int            n_cmp = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    velocity_cell_reader #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .count         (count),
        .count_clamped (count_clamped),
        .mem_address   (mem_address),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_data      (mem_data),
        .mem_q         (mem_q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last)
    );

    // RAM model with a two-stage read pipeline; not affected by rst_n.
    always @(posedge clk) begin
        q_s1 <= (mem_rden && int'(mem_address) < PN) ? ram[mem_address] : '0;
        q_s2 <= q_s1;
    end
    assign mem_q = q_s2;

    function automatic logic [DW-1:0] rec(input int k);
        return {32'hC0DE_0000 + 32'(k), 32'hB0B0_0000 + 32'(k), 32'hA5A5_0000 + 32'(k)};
    endfunction

    task automatic load_ram(input int raw);
        ram[0] = {88'hF0F0_1234_5678_9ABC_DEF0_11, 8'(raw)};
        for (int k = 1; k < PN; k++) ram[k] = rec(k);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({busy, done, count_clamped, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy=%0b done=%0b clamp=%0b count=%0d want all 0", busy, done, count_clamped, count);
        end
        n_cmp++;
        if ({mem_rden, mem_wren, mem_address, mem_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem got rden=%0b wren=%0b addr=%0d data=%h want all 0", mem_rden, mem_wren, mem_address, mem_data);
        end
        n_cmp++;
        if ({out_valid, out_last, out_index, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_out got valid=%0b last=%0b idx=%0d data=%h want all 0", out_valid, out_last, out_index, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({busy, out_valid, mem_rden} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release got busy=%0b valid=%0b rden=%0b want 0", busy, out_valid, mem_rden);
        end
    endtask

    task automatic test_count3;
        int  addrs[$];
        bit  ok;
        load_ram(3);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (mem_rden) addrs.push_back(int'(mem_address));
            n_cmp++;
            if (busy !== (c <= 10)) begin
                n_fail++;
                $display("FAIL count3_busy c=%0d got %0b want %0b", c, busy, (c <= 10));
            end
            n_cmp++;
            if (done !== (c == 10)) begin
                n_fail++;
                $display("FAIL count3_done c=%0d got %0b want %0b", c, done, (c == 10));
            end
            n_cmp++;
            if (out_valid !== (c >= 7 && c <= 9)) begin
                n_fail++;
                $display("FAIL count3_valid c=%0d got %0b want %0b", c, out_valid, (c >= 7 && c <= 9));
            end
            if (c >= 7 && c <= 9) begin
                n_cmp++;
                if (out_index !== AW'(c - 6) || out_data !== rec(c - 6) || out_last !== (c == 9)) begin
                    n_fail++;
                    $display("FAIL count3_rec c=%0d got idx=%0d last=%0b data=%h want idx=%0d last=%0b data=%h",
                             c, out_index, out_last, out_data, c - 6, (c == 9), rec(c - 6));
                end
            end
            tick();
        end
        ok = (addrs.size() == 4);
        for (int i = 0; i < addrs.size() && i < 4; i++) if (addrs[i] != i) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL count3_addrs got %0d reads want 4 reads at 0,1,2,3", addrs.size());
        end
        n_cmp++;
        if (count !== AW'(3) || count_clamped !== 1'b0) begin
            n_fail++;
            $display("FAIL count3_count got count=%0d clamp=%0b want 3/0", count, count_clamped);
        end
    endtask

    task automatic test_count0;
        int addrs[$];
        load_ram(0);
        out_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            if (mem_rden) addrs.push_back(int'(mem_address));
            n_cmp++;
            if (done !== (c == 4) || busy !== (c <= 4) || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL count0_ctrl c=%0d got done=%0b busy=%0b valid=%0b want %0b/%0b/0",
                         c, done, busy, out_valid, (c == 4), (c <= 4));
            end
            tick();
        end
        n_cmp++;
        if (addrs.size() != 1 || addrs[0] != 0) begin
            n_fail++;
            $display("FAIL count0_addrs got %0d reads want a single read at 0", addrs.size());
        end
    endtask

    task automatic test_backpressure;
        int            expect_idx;
        int            issued;
        int            hs;
        int            c;
        bit            stalled;
        bit            seen_done;
        logic [DW-1:0] held_data;
        logic [AW-1:0] held_idx;
        logic          held_last;
        expect_idx = 1; issued = 0; hs = 0; stalled = 0; seen_done = 0;
        held_data = '0; held_idx = '0; held_last = 1'b0;
        load_ram(5);
        out_ready = 1'b0;
        pulse_start();
        c = 1;
        while (!seen_done && c < 80) begin
            out_ready = (c % 3 == 1);
            #1;
            if (mem_rden && mem_address != '0) issued++;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_index !== held_idx || out_last !== held_last) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d got valid=%0b idx=%0d want held idx=%0d", c, out_valid, out_index, held_idx);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_index !== AW'(expect_idx) || out_data !== rec(expect_idx) || out_last !== (expect_idx == 5)) begin
                    n_fail++;
                    $display("FAIL bp_rec c=%0d got idx=%0d last=%0b want idx=%0d last=%0b",
                             c, out_index, out_last, expect_idx, (expect_idx == 5));
                end
                expect_idx++;
                hs++;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_index;
            held_last = out_last;
            n_cmp++;
            if (issued - hs > RL + 1) begin
                n_fail++;
                $display("FAIL bp_credit c=%0d got outstanding=%0d want <= %0d", c, issued - hs, RL + 1);
            end
            if (done) seen_done = 1'b1;
            tick();
            c++;
        end
        n_cmp++;
        if (!seen_done || hs != 5 || issued != 5) begin
            n_fail++;
            $display("FAIL bp_total got done=%0b records=%0d reads=%0d want 1/5/5", seen_done, hs, issued);
        end
    endtask

    task automatic test_clamp;
        int expect_idx;
        int max_addr;
        int last_idx;
        int c;
        bit seen_done;
        expect_idx = 1; max_addr = 0; last_idx = -1; seen_done = 0;
        load_ram(250);
        out_ready = 1'b1;
        pulse_start();
        c = 1;
        while (!seen_done && c < 600) begin
            if (mem_rden) begin
                if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
                n_cmp++;
                if (int'(mem_address) > PN - 1) begin
                    n_fail++;
                    $display("FAIL clamp_addr c=%0d got addr=%0d want <= %0d", c, mem_address, PN - 1);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_index !== AW'(expect_idx) || out_data !== rec(expect_idx) || out_last !== (expect_idx == PN - 1)) begin
                    n_fail++;
                    $display("FAIL clamp_rec c=%0d got idx=%0d last=%0b want idx=%0d", c, out_index, out_last, expect_idx);
                end
                if (out_last) last_idx = int'(out_index);
                expect_idx++;
            end
            if (done) seen_done = 1'b1;
            tick();
            c++;
        end
        n_cmp++;
        if (count !== AW'(PN - 1) || count_clamped !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_count got count=%0d clamp=%0b want %0d/1", count, count_clamped, PN - 1);
        end
        n_cmp++;
        if (!seen_done || last_idx != PN - 1 || max_addr != PN - 1 || expect_idx != PN) begin
            n_fail++;
            $display("FAIL clamp_stream got done=%0b last=%0d maxaddr=%0d records=%0d want 1/%0d/%0d/%0d",
                     seen_done, last_idx, max_addr, expect_idx - 1, PN - 1, PN - 1, PN - 1);
        end
    endtask

    task automatic test_start_ignored;
        int addrs[$];
        bit ok;
        load_ram(4);
        out_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if (count_clamped !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_clamp_clear got %0b want 0", count_clamped);
        end
        for (int c = 1; c <= 14; c++) begin
            start = (c == 3 || c == 8);
            if (mem_rden) addrs.push_back(int'(mem_address));
            n_cmp++;
            if (done !== (c == 11) || busy !== (c <= 11) || out_valid !== (c >= 7 && c <= 10)) begin
                n_fail++;
                $display("FAIL ign_ctrl c=%0d got done=%0b busy=%0b valid=%0b want %0b/%0b/%0b",
                         c, done, busy, out_valid, (c == 11), (c <= 11), (c >= 7 && c <= 10));
            end
            if (c >= 7 && c <= 10) begin
                n_cmp++;
                if (out_index !== AW'(c - 6) || out_last !== (c == 10)) begin
                    n_fail++;
                    $display("FAIL ign_rec c=%0d got idx=%0d last=%0b want idx=%0d last=%0b", c, out_index, out_last, c - 6, (c == 10));
                end
            end
            tick();
        end
        start = 1'b0;
        ok = (addrs.size() == 5);
        for (int i = 0; i < addrs.size() && i < 5; i++) if (addrs[i] != i) ok = 1'b0;
        n_cmp++;
        if (!ok || count !== AW'(4)) begin
            n_fail++;
            $display("FAIL ign_addrs got %0d reads count=%0d want 5 reads 0..4 count=4", addrs.size(), count);
        end
    endtask

    task automatic test_reset_midstream;
        int hs;
        int c;
        int expect_idx;
        bit seen_done;
        hs = 0; c = 0;
        load_ram(8);
        out_ready = 1'b1;
        pulse_start();
        while (hs < 2 && c < 40) begin
            if (out_valid && out_ready) hs++;
            tick();
            c++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, count_clamped, count, mem_rden, mem_address} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl got busy=%0b done=%0b count=%0d rden=%0b addr=%0d want all 0",
                     busy, done, count, mem_rden, mem_address);
        end
        n_cmp++;
        if ({out_valid, out_last, out_index, out_data} !== '0 || hs != 2) begin
            n_fail++;
            $display("FAIL rstmid_out got valid=%0b idx=%0d beats=%0d want 0/0/2", out_valid, out_index, hs);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_late k=%0d got valid=%0b busy=%0b want 0/0", k, out_valid, busy);
            end
        end
        expect_idx = 1; seen_done = 0; c = 0;
        pulse_start();
        while (!seen_done && c < 40) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_index !== AW'(expect_idx) || out_data !== rec(expect_idx) || out_last !== (expect_idx == 8)) begin
                    n_fail++;
                    $display("FAIL rstmid_rec got idx=%0d last=%0b want idx=%0d last=%0b", out_index, out_last, expect_idx, (expect_idx == 8));
                end
                expect_idx++;
            end
            if (done) seen_done = 1'b1;
            tick();
            c++;
        end
        n_cmp++;
        if (!seen_done || expect_idx != 9 || count !== AW'(8)) begin
            n_fail++;
            $display("FAIL rstmid_restart got done=%0b records=%0d count=%0d want 1/8/8", seen_done, expect_idx - 1, count);
        end
    endtask

    initial begin
        test_reset();
        test_count3();
        test_count0();
        test_backpressure();
        test_clamp();
        test_start_ignored();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion within time limit want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
